// File: rtl/gpio_pad_ctrl_if.sv
// Core-side bundle of the GPIO pad controller: output drive, filtered input readback
// and per-pin edge-interrupt control/status.
interface gpio_pad_ctrl_if #(
    parameter int NPINS = 32
);
    logic [NPINS-1:0] io_oe;
    logic [NPINS-1:0] io_oval;
    logic [NPINS-1:0] io_ival;
    logic [NPINS-1:0] rise_ie;
    logic [NPINS-1:0] fall_ie;
    logic [NPINS-1:0] pend_clr;
    logic [NPINS-1:0] pend;
    logic             irq;

    modport master (
        output io_oe, io_oval, rise_ie, fall_ie, pend_clr,
        input  io_ival, pend, irq
    );

    modport slave (
        input  io_oe, io_oval, rise_ie, fall_ie, pend_clr,
        output io_ival, pend, irq
    );
endinterface

// File: rtl/gpio_pad_ctrl.sv
// GPIO pad controller: registered output/enable path, per-pin synchroniser and
// debounce filter, and sticky edge-interrupt pending bits with a combined irq.
module gpio_pad_ctrl #(
    parameter int NPINS        = 32,
    parameter int SYNC_STAGES  = 2,
    parameter int DEBOUNCE_CNT = 0
) (
    input  logic             clock,
    input  logic             reset,
    gpio_pad_ctrl_if.slave   core,
    input  logic [NPINS-1:0] pad_i,
    output logic [NPINS-1:0] pad_o,
    output logic [NPINS-1:0] pad_oe
);
    localparam int CW = (DEBOUNCE_CNT > 0) ? $clog2(DEBOUNCE_CNT + 1) : 1;
    localparam logic [CW-1:0] DB_MAX = CW'(DEBOUNCE_CNT);

    logic [NPINS-1:0] stable_vec;
    logic [NPINS-1:0] pend_vec;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            pad_o  <= '0;
            pad_oe <= '0;
        end else begin
            pad_o  <= core.io_oval;
            pad_oe <= core.io_oe;
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < NPINS; gi++) begin : g_pin
            logic [SYNC_STAGES-1:0] sync_chain_reg;
            logic [CW-1:0]          cnt_reg;
            logic                   stable_reg;
            logic                   pend_reg;
            logic                   sync_bit;
            logic                   differ;
            logic                   accept;
            logic                   set_evt;

            assign sync_bit = sync_chain_reg[SYNC_STAGES-1];
            assign differ   = sync_bit ^ stable_reg;
            // The change is accepted on the edge after it has already been seen
            // DEBOUNCE_CNT times, so a pulse must last DEBOUNCE_CNT+1 cycles.
            assign accept   = differ && (cnt_reg == DB_MAX);
            assign set_evt  = accept && (sync_bit ? core.rise_ie[gi] : core.fall_ie[gi]);

            always_ff @(posedge clock or posedge reset) begin
                if (reset) begin
                    sync_chain_reg <= '0;
                    cnt_reg        <= '0;
                    stable_reg     <= 1'b0;
                    pend_reg       <= 1'b0;
                end else begin
                    sync_chain_reg <= {sync_chain_reg[SYNC_STAGES-2:0], pad_i[gi]};
                    if (!differ || accept) begin
                        cnt_reg <= '0;
                    end else begin
                        cnt_reg <= cnt_reg + CW'(1);
                    end
                    if (accept) begin
                        stable_reg <= sync_bit;
                    end
                    // A new event outranks a simultaneous clear.
                    pend_reg <= set_evt | (pend_reg & ~core.pend_clr[gi]);
                end
            end

            assign stable_vec[gi] = stable_reg;
            assign pend_vec[gi]   = pend_reg;
        end
    endgenerate

    assign core.io_ival = stable_vec;
    assign core.pend    = pend_vec;
    assign core.irq     = |pend_vec;
endmodule

// File: tb/tb_gpio_pad_ctrl.sv
// Bench for gpio_pad_ctrl: two instances (debounce 3 and bypass) share stimulus;
// a reference model feeds per-cycle scoreboards, plus directed spot checks.
module tb_gpio_pad_ctrl;
    localparam int N  = 4;
    localparam int SS = 2;

    logic clk   = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    logic [N-1:0] oe = '0, oval = '0, rie = '0, fie = '0, pclr = '0, pad = '0;
    logic [N-1:0] pad_o0, pad_oe0, pad_o1, pad_oe1;

    gpio_pad_ctrl_if #(.NPINS(N)) core0 ();
    gpio_pad_ctrl_if #(.NPINS(N)) core1 ();

    assign core0.io_oe = oe;   assign core1.io_oe = oe;
    assign core0.io_oval = oval; assign core1.io_oval = oval;
    assign core0.rise_ie = rie;  assign core1.rise_ie = rie;
    assign core0.fall_ie = fie;  assign core1.fall_ie = fie;
    assign core0.pend_clr = pclr; assign core1.pend_clr = pclr;

    gpio_pad_ctrl #(.NPINS(N), .SYNC_STAGES(SS), .DEBOUNCE_CNT(3)) u_dut0 (
        .clock(clk), .reset(reset), .core(core0), .pad_i(pad), .pad_o(pad_o0), .pad_oe(pad_oe0)
    );
    gpio_pad_ctrl #(.NPINS(N), .SYNC_STAGES(SS), .DEBOUNCE_CNT(0)) u_dut1 (
        .clock(clk), .reset(reset), .core(core1), .pad_i(pad), .pad_o(pad_o1), .pad_oe(pad_oe1)
    );

    typedef struct {
        logic [N-1:0] ival;
        logic [N-1:0] pend;
        logic [N-1:0] po;
        logic [N-1:0] poe;
        logic         irq;
    } exp_t;

    exp_t q0[$];
    exp_t q1[$];
    int errors = 0;
    int checks = 0;

    task automatic check(input string name, input logic [N-1:0] act, input logic [N-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: a pin's filtered value flips once the synchronised input
    // has disagreed with it on db+1 consecutive clock edges.
    int           db [2] = '{3, 0};
    logic [N-1:0] m_ival [2] = '{'0, '0};
    logic [N-1:0] m_pend [2] = '{'0, '0};
    logic [N-1:0] m_po = '0, m_poe = '0;
    int           run [2][N];
    logic [N-1:0] pipe[$];

    always @(posedge clk) begin : model
        logic [N-1:0] s;
        logic [N-1:0] setv;
        exp_t e;
        if (reset) begin
            for (int k = 0; k < 2; k++) begin
                m_ival[k] = '0;
                m_pend[k] = '0;
                for (int i = 0; i < N; i++) run[k][i] = 0;
            end
            m_po  = '0;
            m_poe = '0;
            pipe.delete();
            for (int j = 0; j < SS; j++) pipe.push_back('0);
        end else begin
            s = pipe.pop_front();
            pipe.push_back(pad);
            for (int k = 0; k < 2; k++) begin
                setv = '0;
                for (int i = 0; i < N; i++) begin
                    if (s[i] != m_ival[k][i]) begin
                        run[k][i]++;
                        if (run[k][i] == db[k] + 1) begin
                            m_ival[k][i] = s[i];
                            run[k][i] = 0;
                            setv[i] = s[i] ? rie[i] : fie[i];
                        end
                    end else begin
                        run[k][i] = 0;
                    end
                end
                m_pend[k] = setv | (m_pend[k] & ~pclr);
            end
            m_po  = oval;
            m_poe = oe;
        end
        e.po = m_po; e.poe = m_poe;
        e.ival = m_ival[0]; e.pend = m_pend[0]; e.irq = |m_pend[0];
        q0.push_back(e);
        e.ival = m_ival[1]; e.pend = m_pend[1]; e.irq = |m_pend[1];
        q1.push_back(e);
    end

    always @(negedge clk) begin : monitor
        exp_t e0, e1;
        if (q0.size() == 0 || q1.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL sb_underflow: got empty queue expected one entry at %0t", $time);
        end else begin
            e0 = q0.pop_front();
            e1 = q1.pop_front();
            if (reset) begin
                e0 = '{default: '0};
                e1 = '{default: '0};
            end
            check("sb0_ival", core0.io_ival, e0.ival);
            check("sb0_pend", core0.pend, e0.pend);
            check("sb0_irq", N'(core0.irq), N'(e0.irq));
            check("sb0_pad_o", pad_o0, e0.po);
            check("sb0_pad_oe", pad_oe0, e0.poe);
            check("sb1_ival", core1.io_ival, e1.ival);
            check("sb1_pend", core1.pend, e1.pend);
            check("sb1_irq", N'(core1.irq), N'(e1.irq));
            check("sb1_pad_o", pad_o1, e1.po);
            check("sb1_pad_oe", pad_oe1, e1.poe);
        end
    end

    initial begin : stim
        repeat (2) @(negedge clk);
        check("rst_ival", core0.io_ival, '0);
        check("rst_irq", N'(core0.irq), '0);
        reset = 1'b0;

        // output path: one clock of delay, not zero
        @(negedge clk); oe = 4'b0101; oval = 4'b0011;
        #1 check("out_before_edge", pad_oe0, 4'b0000);
        @(posedge clk); #1;
        check("out_oe_1clk", pad_oe0, 4'b0101);
        check("out_o_1clk", pad_o0, 4'b0011);

        // debounce latency on pin 0
        @(negedge clk); rie = 4'b0001;
        @(negedge clk); pad[0] = 1'b1;
        for (int c = 1; c <= 6; c++) begin
            @(posedge clk); #1;
            check("lat_ival", core0.io_ival, (c == 6) ? 4'b0001 : 4'b0000);
            check("lat_pend", core0.pend, (c == 6) ? 4'b0001 : 4'b0000);
            check("lat_irq", N'(core0.irq), (c == 6) ? 4'b0001 : 4'b0000);
            if (c == 2 || c == 3) check("byp_lat", core1.io_ival, (c == 3) ? 4'b0001 : 4'b0000);
        end
        @(negedge clk); pclr = 4'b0001;
        @(negedge clk); pclr = 4'b0000;
        check("clr_pend0", core0.pend, 4'b0000);

        // glitch reject on pin 1, then a 4-cycle pulse is accepted
        rie = 4'b0011;
        pad[1] = 1'b1; repeat (3) @(negedge clk); pad[1] = 1'b0;
        repeat (8) @(negedge clk);
        check("glitch_ival", core0.io_ival, 4'b0001);
        check("glitch_pend", core0.pend, 4'b0000);
        pad[1] = 1'b1; repeat (4) @(negedge clk); pad[1] = 1'b0;
        repeat (8) @(negedge clk);
        check("pulse4_pend", core0.pend, 4'b0010);

        // bypass instance accepts a single-cycle pulse
        pclr = '1; @(negedge clk); pclr = '0;
        pad[1] = 1'b1; @(negedge clk); pad[1] = 1'b0;
        repeat (6) @(negedge clk);
        check("byp_pulse_pend", core1.pend, 4'b0010);
        check("dbn_pulse_pend", core0.pend, 4'b0000);

        // fall interrupt and clear on pin 2
        fie = 4'b0100;
        pad[2] = 1'b1; repeat (8) @(negedge clk);
        check("fall_rise_nopend", core0.pend, 4'b0000);
        pad[2] = 1'b0; repeat (8) @(negedge clk);
        check("fall_pend", core0.pend, 4'b0100);
        pclr = 4'b0100;
        @(posedge clk); #1 check("fall_clr", core0.pend, 4'b0000);
        @(negedge clk); pclr = '0;
        pad[2] = 1'b1; repeat (8) @(negedge clk);
        check("fall_rise_after", core0.pend, 4'b0000);
        check("fall_rise_ival", core0.io_ival, 4'b0101);

        // set/clear collision on pin 3
        rie = 4'b1011;
        pad[3] = 1'b1; repeat (5) @(negedge clk);
        pclr = 4'b1000;
        @(posedge clk); #1;
        check("collide_pend", core0.pend, 4'b1000);
        @(negedge clk); pclr = '0;

        // reset mid-debounce on pin 0
        pad[0] = 1'b0; repeat (8) @(negedge clk);
        pclr = '1; @(negedge clk); pclr = '0;
        pad[0] = 1'b1;
        repeat (4) @(posedge clk);
        #2 reset = 1'b1;
        #1;
        check("rst_mid_ival", core0.io_ival, '0);
        check("rst_mid_pend", core0.pend, '0);
        check("rst_mid_pad_oe", pad_oe0, '0);
        check("rst_mid_pad_o", pad_o0, '0);
        @(negedge clk); @(negedge clk); reset = 1'b0;
        for (int c = 1; c <= 6; c++) begin
            @(posedge clk); #1;
            check("rst_lat_ival", core0.io_ival, (c == 6) ? 4'b1101 : 4'b0000);
            check("rst_lat_pend", core0.pend, (c == 6) ? 4'b1001 : 4'b0000);
        end

        // randomised traffic, scoreboard only
        for (int n = 0; n < 400; n++) begin
            @(negedge clk);
            pad  = pad ^ N'($urandom & $urandom);
            pclr = N'($urandom & $urandom & $urandom);
            oe   = N'($urandom);
            oval = N'($urandom);
            if ($urandom_range(0, 7) == 0) rie = N'($urandom);
            if ($urandom_range(0, 7) == 0) fie = N'($urandom);
            if ($urandom_range(0, 99) == 0) begin
                #1 reset = 1'b1;
                @(negedge clk); reset = 1'b0;
            end
        end
        pclr = '0;
        repeat (3) @(negedge clk);
        #2;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
